// File: rtl/calli_pkg.sv
// Shared definitions for the stroke executor: opcodes, FSM states, the home
// direction and the command count decode.
package calli_pkg;

  localparam logic [1:0] OP_MOVE_X = 2'b00;
  localparam logic [1:0] OP_MOVE_Y = 2'b01;
  localparam logic [1:0] OP_PEN    = 2'b10;
  localparam logic [1:0] OP_DWELL  = 2'b11;

  // Direction value that drives an axis toward its limit switch.
  localparam logic DIR_HOME = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_PEN_WAIT,
    ST_DWELL,
    ST_DONE
  } state_t;

  // Command count field: 0 encodes 32, anything else is taken literally.
  function automatic logic [5:0] count_decode(input logic [4:0] n);
    return (n == 5'd0) ? 6'd32 : {1'b0, n};
  endfunction

endpackage

// File: rtl/stroke_exec_step_pulse_gen.sv
// Step period timebase: while run is high, counts 0..STEP_DIV-1 repeatedly.
// step is high for the first STEP_DIV/2 counts of every period; hi_end marks
// the last high cycle and step_done the last cycle of the period.
module step_pulse_gen #(
  parameter int STEP_DIV = 200,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic step,
  output logic hi_end,
  output logic step_done
);

  localparam int HALF = STEP_DIV / 2;

  logic [CNT_W-1:0] cnt_reg;

  // Period counter; parked at 0 whenever not running so each stroke starts clean.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(STEP_DIV - 1)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign step      = run && (cnt_reg < CNT_W'(HALF));
  assign hi_end    = run && (cnt_reg == CNT_W'(HALF - 1));
  assign step_done = run && (cnt_reg == CNT_W'(STEP_DIV - 1));

endmodule

// File: rtl/stroke_exec.sv
// Stroke executor: runs one 8-bit stroke command (X/Y move, pen, dwell) per
// go handshake and raises fin when complete.
// Optional feature: define LIMIT_SW_EN to abort homing moves on a limit switch.
module stroke_exec
  import calli_pkg::*;
#(
  parameter int STEP_DIV   = 200,
  parameter int STEP_MULT  = 8,
  parameter int PEN_SETTLE = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       go,
  output logic       fin,
  output logic       busy,
  output logic       x_step,
  output logic       x_dir,
  output logic       y_step,
  output logic       y_dir,
  output logic       pen,
  input  logic       x_lim,
  input  logic       y_lim,
  output logic       err
);

  localparam int STEP_W  = $clog2(32 * STEP_MULT + 1);
  localparam int DIV_MAX = (STEP_DIV > PEN_SETTLE) ? STEP_DIV : PEN_SETTLE;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] PEN_LAST = DIV_W'(PEN_SETTLE - 1);

  state_t             state_reg, state_next;
  logic [7:0]         cmd_q_reg;
  logic [STEP_W-1:0]  steps_reg, steps_next;
  logic [DIV_W-1:0]   wait_reg, wait_next;
  logic               pen_reg, pen_next;
  logic               err_reg, err_next;
  logic               x_dir_reg, y_dir_reg;
  logic               go_s1_reg, go_s2_reg, go_s3_reg;
  logic               go_rise;
  logic [1:0]         op;
  logic               move_run, dwell_run, gen_run;
  logic               gen_step, hi_end, step_done;
  logic               lim_hit;

  assign go_rise = go_s2_reg && !go_s3_reg;
  assign op      = cmd_q_reg[7:6];

`ifdef LIMIT_SW_EN
  logic [1:0] lim_raw;
  logic [1:0] lim_sync;
  assign lim_raw = {y_lim, x_lim};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lim_sync
      logic s1_reg, s2_reg;
      // Two-flop synchroniser for one limit switch.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= lim_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign lim_sync[gi] = s2_reg;
    end
  endgenerate

  // Abort only when the moving axis is driving into its own switch.
  assign lim_hit = (op == OP_MOVE_X) ? (lim_sync[0] && (x_dir_reg == DIR_HOME)) :
                   (op == OP_MOVE_Y) ? (lim_sync[1] && (y_dir_reg == DIR_HOME)) :
                   1'b0;
`else
  logic unused_lim;
  assign unused_lim = x_lim ^ y_lim;
  assign lim_hit    = 1'b0;
`endif

  // State, counters, go synchroniser and command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cmd_q_reg <= '0;
      steps_reg <= '0;
      wait_reg  <= '0;
      pen_reg   <= 1'b0;
      err_reg   <= 1'b0;
      x_dir_reg <= 1'b0;
      y_dir_reg <= 1'b0;
      go_s1_reg <= 1'b0;
      go_s2_reg <= 1'b0;
      go_s3_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      steps_reg <= steps_next;
      wait_reg  <= wait_next;
      pen_reg   <= pen_next;
      err_reg   <= err_next;
      go_s1_reg <= go;
      go_s2_reg <= go_s1_reg;
      go_s3_reg <= go_s2_reg;
      // dir loads together with cmd_q so it leads the first step edge by
      // the whole DECODE cycle.
      if (state_reg == ST_IDLE && go_rise) begin
        cmd_q_reg <= cmd;
        if (cmd[7:6] == OP_MOVE_X) x_dir_reg <= cmd[5];
        if (cmd[7:6] == OP_MOVE_Y) y_dir_reg <= cmd[5];
      end
    end
  end

  // Next-state logic and per-state counter updates.
  always_comb begin
    state_next = state_reg;
    steps_next = steps_reg;
    wait_next  = wait_reg;
    pen_next   = pen_reg;
    err_next   = err_reg;
    move_run   = 1'b0;
    dwell_run  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go_rise) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        steps_next = STEP_W'(32'(count_decode(cmd_q_reg[4:0])) * STEP_MULT);
        wait_next  = '0;
        case (op)
          OP_MOVE_X, OP_MOVE_Y: state_next = ST_STEP_HI;
          OP_PEN: begin
            pen_next   = cmd_q_reg[0];
            state_next = ST_PEN_WAIT;
          end
          default: state_next = ST_DWELL;
        endcase
      end
      ST_STEP_HI: begin
        move_run = 1'b1;
        if (lim_hit) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
          steps_next = '0;
        end else if (hi_end) begin
          state_next = ST_STEP_LO;
        end
      end
      ST_STEP_LO: begin
        move_run = 1'b1;
        if (lim_hit) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
          steps_next = '0;
        end else if (step_done) begin
          steps_next = steps_reg - 1'b1;
          state_next = (steps_reg == STEP_W'(1)) ? ST_DONE : ST_STEP_HI;
        end
      end
      ST_PEN_WAIT: begin
        if (wait_reg == PEN_LAST) state_next = ST_DONE;
        else                      wait_next  = wait_reg + 1'b1;
      end
      ST_DWELL: begin
        // Dwell reuses the step timebase with the step outputs masked.
        dwell_run = 1'b1;
        if (step_done) begin
          steps_next = steps_reg - 1'b1;
          if (steps_reg == STEP_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!go_s2_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign gen_run = move_run || dwell_run;

  step_pulse_gen #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (DIV_W)
  ) u_step_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (gen_run),
    .step      (gen_step),
    .hi_end    (hi_end),
    .step_done (step_done)
  );

  assign x_step = gen_step && move_run && (op == OP_MOVE_X);
  assign y_step = gen_step && move_run && (op == OP_MOVE_Y);
  assign x_dir  = x_dir_reg;
  assign y_dir  = y_dir_reg;
  assign pen    = pen_reg;
  assign err    = err_reg;
  assign fin    = (state_reg == ST_DONE);
  assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_stroke_exec.sv
// Self-checking bench for stroke_exec: a cycle-timeline model computed from
// the command rules, a per-cycle compare, directed scenarios and random strokes.
module tb_stroke_exec;

  localparam int SD = 8;
  localparam int SM = 2;
  localparam int PS = 20;
  localparam int H  = SD / 2;

  logic       clk = 1'b0;
  logic       rst, go, x_lim, y_lim;
  logic [7:0] cmd;
  logic       fin, busy, x_step, x_dir, y_step, y_dir, pen, err;

  int errors = 0;
  int checks = 0;

  stroke_exec #(.STEP_DIV(SD), .STEP_MULT(SM), .PEN_SETTLE(PS)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .go(go), .fin(fin), .busy(busy),
    .x_step(x_step), .x_dir(x_dir), .y_step(y_step), .y_dir(y_dir),
    .pen(pen), .x_lim(x_lim), .y_lim(y_lim), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: stroke timeline -----------------
  // k counts clock edges. A go rise seen two edges earlier (synchroniser)
  // latches the stroke at edge L; dir follows at L, pen at L+1, stepping or
  // waiting occupies edges L+1 .. L+dur, fin from L+1+dur until go is seen low.
  bit   model_on = 1'b1;
  int   k = 0, m_act = 0, m_start = 0, m_done_e = 0, m_op = 0, m_dur = 0, m_n = 0, j;
  logic [7:0] m_cmd;
  bit   p1, p2, p3;
  bit   ex_xdir, ex_ydir, ex_pen, ex_err, ex_busy, ex_fin, ex_xs, ex_ys;

  initial begin : model
    forever begin
      @(posedge clk);
      k++;
      if (rst) begin
        m_act = 0; ex_xdir = 0; ex_ydir = 0; ex_pen = 0; ex_err = 0;
        p1 = 0; p2 = 0; p3 = 0;
      end else begin
        if (m_act != 0) begin
          if (k - 1 >= m_done_e && !p2) m_act = 0;
          else if (k == m_start + 1 && m_op == 2) ex_pen = m_cmd[0];
        end else if (p2 && !p3) begin
          m_act = 1; m_start = k; m_cmd = cmd; m_op = int'(cmd[7:6]);
          m_n   = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
          m_dur = (m_op == 2) ? PS : m_n * SM * SD;
          m_done_e = m_start + 1 + m_dur;
          if (m_op == 0) ex_xdir = cmd[5];
          if (m_op == 1) ex_ydir = cmd[5];
        end
        p3 = p2; p2 = p1; p1 = go;
      end
      ex_busy = (m_act != 0);
      ex_fin  = (m_act != 0) && (k >= m_done_e);
      j = k - (m_start + 1);
      ex_xs = (m_act != 0) && m_op == 0 && j >= 0 && j < m_dur && (j % SD) < H;
      ex_ys = (m_act != 0) && m_op == 1 && j >= 0 && j < m_dur && (j % SD) < H;
    end
  end

  // ---------------- per-cycle compare and pulse monitor --------------
  int xs_rise = 0, ys_rise = 0, xs_hi = 0, xs_lo = 0, width_err = 0;
  bit first_dir = 0, prev_xs = 0, prev_ys = 0, prev_xdir = 0;
  logic [7:0] got, want;

  initial begin : cmp
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        got  = {busy, fin, x_step, x_dir, y_step, y_dir, pen, err};
        want = {ex_busy, ex_fin, ex_xs, ex_xdir, ex_ys, ex_ydir, ex_pen, ex_err};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cycle_cmp t=%0t busy/fin/xs/xd/ys/yd/pen/err got=%b want=%b",
                   $time, got, want);
        end
      end
      if (x_step && !prev_xs) begin
        if (xs_rise > 0 && xs_lo != SD - H) width_err++;
        if (xs_rise == 0) first_dir = prev_xdir;
        xs_rise++;
        xs_hi = 0;
      end
      if (!x_step && prev_xs) begin
        if (xs_hi != H) width_err++;
        xs_lo = 0;
      end
      if (x_step) xs_hi++; else xs_lo++;
      if (y_step && !prev_ys) ys_rise++;
      prev_xs = x_step; prev_ys = y_step; prev_xdir = x_dir;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers -------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] c);
    @(negedge clk);
    cmd = c;
    go  = 1'b1;
  endtask

  task automatic clr_mon();
    xs_rise = 0; ys_rise = 0; width_err = 0; first_dir = 0;
  endtask

  task automatic wait_fin(input string name, input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (fin) begin lat = i; break; end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s: fin got 0 after %0d clk, want 1", name, budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int ok;
    ok = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (ok == 0) begin
      checks++; errors++;
      $display("FAIL %s: busy got 1 after %0d clk, want 0", name, budget);
    end
  endtask

  task automatic wait_xs(input string name, input int cnt, input int budget);
    int ok;
    ok = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (xs_rise >= cnt && !x_step) begin ok = 1; break; end
    end
    if (ok == 0) begin
      checks++; errors++;
      $display("FAIL %s: x_step pulses got %0d, want %0d", name, xs_rise, cnt);
    end
  endtask

  // ---------------- stimulus ------------------------------------------
  int lat, lat2, n;
  logic [7:0] c;

  initial begin : stim
    rst = 1'b1; go = 1'b0; cmd = 8'h00; x_lim = 1'b0; y_lim = 1'b0;
    cyc(3);
    chk("reset_outputs", int'({busy, fin, x_step, x_dir, y_step, y_dir, pen, err}), 0);
    rst = 1'b0;
    cyc(2);

    // Move X, dir 1, n=3 -> 6 pulses of 4 high / 4 low.
    clr_mon();
    start(8'h23);
    wait_fin("t1_fin", 200, lat);
    chk("t1_go_to_fin_clk", lat, 52);
    chk("t1_x_pulses", xs_rise, 6);
    chk("t1_y_pulses", ys_rise, 0);
    chk("t1_pulse_width_errs", width_err, 0);
    chk("t1_dir_before_step", int'(first_dir), 1);
    // Hold go high: fin must stay; then drop it and fin/busy clear 3 clk later.
    cyc(5);
    chk("t4_fin_held", int'(fin), 1);
    go = 1'b0;
    cyc(2);
    chk("t4_fin_2clk", int'(fin), 1);
    cyc(1);
    chk("t4_fin_3clk", int'(fin), 0);
    chk("t4_busy_3clk", int'(busy), 0);
    cyc(3);

    // Move Y, dir 0, n=0 (32) with a go drop and a second go rise mid-stroke.
    clr_mon();
    start(8'h40);
    cyc(30); go = 1'b0;
    cyc(20); go = 1'b1;
    cyc(20); go = 1'b0;
    wait_fin("t2_fin", 600, lat);
    chk("t2_y_pulses", ys_rise, 32 * SM);
    chk("t2_x_pulses", xs_rise, 0);
    chk("t2_y_dir", int'(y_dir), 0);
    wait_idle("t2_idle", 10);
    cyc(10);
    chk("t4_second_rise_ignored", int'(busy), 0);

    // Pen down, then pen up twice (second wait applies though already up).
    start(8'h81);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pen) begin lat = i; break; end
    end
    chk("t3_pen_down_clk", lat, 4);
    wait_fin("t3_fin", 100, lat2);
    chk("t3_settle_clk", lat2, PS);
    go = 1'b0;
    wait_idle("t3_idle", 10);
    cyc(2);
    start(8'h80);
    wait_fin("t3_fin_up", 100, lat);
    chk("t3_pen_up", int'(pen), 0);
    go = 1'b0;
    wait_idle("t3_idle_up", 10);
    cyc(2);
    start(8'h80);
    wait_fin("t3_fin_up2", 100, lat);
    chk("t3_full_wait_same_level", lat, PS + 4);
    go = 1'b0;
    wait_idle("t3_idle_up2", 10);
    cyc(2);

    // Reset during the 3rd step, then a normal stroke.
    clr_mon();
    start(8'h03);
    wait_xs("t5_reach_step3", 2, 100);
    @(negedge clk);
    while (!x_step) @(negedge clk);
    rst = 1'b1; go = 1'b0;
    @(negedge clk);
    chk("t5_reset_outputs", int'({busy, fin, x_step, x_dir, y_step, y_dir, pen, err}), 0);
    rst = 1'b0;
    cyc(3);
    clr_mon();
    start(8'h21);
    wait_fin("t5_fin", 100, lat);
    chk("t5_x_pulses", xs_rise, 2);
    chk("t5_x_dir", int'(x_dir), 1);
    go = 1'b0;
    wait_idle("t5_idle", 10);
    cyc(2);

    // Random strokes with go jitter and command changes after the latch.
    for (int r = 0; r < 25; r++) begin
      c = 8'($urandom);
      n = (c[4:0] == 5'd0) ? 32 : int'(c[4:0]);
      start(c);
      if (c[7:6] != 2'b10 && n >= 4 && $urandom_range(0, 1) == 1) begin
        cyc($urandom_range(3, 30));
        go = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          cyc($urandom_range(1, 10));
          go = 1'b1;
        end
      end
`ifndef LIMIT_SW_EN
      x_lim = 1'($urandom);
      y_lim = 1'($urandom);
`endif
      wait_fin("rnd_fin", 700, lat);
      cmd = 8'($urandom);
      cyc($urandom_range(0, 4));
      go = 1'b0;
      wait_idle("rnd_idle", 20);
      cyc($urandom_range(0, 4));
    end
    x_lim = 1'b0; y_lim = 1'b0;
    cyc(3);

    // Limit switch on a homing X move after 2 steps.
    clr_mon();
    start(8'h05);
    wait_xs("t6_two_steps", 2, 100);
`ifdef LIMIT_SW_EN
    model_on = 1'b0;
    x_lim = 1'b1;
    wait_fin("t6_fin", 100, lat);
    chk("t6_x_pulses", xs_rise, 2);
    chk("t6_err", int'(err), 1);
    cyc(10);
    chk("t6_no_more_steps", xs_rise, 2);
`else
    x_lim = 1'b1;
    wait_fin("t6_fin", 200, lat);
    chk("t6_x_pulses", xs_rise, 5 * SM);
    chk("t6_err", int'(err), 0);
`endif
    go = 1'b0;
    x_lim = 1'b0;
    wait_idle("t6_idle", 10);
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
